// File: rtl/fft_stage_buffer.sv
// N-point sample register bank for the FFT datapath: serial (optionally bit-reversed) fill,
// per-stage butterfly writebacks exposed on a parallel bus, then natural-order serial drain.
module fft_stage_buffer #(
  parameter int N      = 16,
  parameter int W      = 16,
  parameter int BITREV = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  input  logic [W-1:0]                       in_data,
  output logic                               in_ready,
  output logic                               calc_active,
  output logic [$clog2($clog2(N)+1)-1:0]     stage,
  output logic [N*W-1:0]                     data_out,
  input  logic                               wb_valid,
  input  logic [$clog2(N)-1:0]               wb_addr,
  input  logic [W-1:0]                       wb_data,
  input  logic                               stage_done,
  output logic                               out_valid,
  output logic [W-1:0]                       out_data,
  output logic                               out_last,
  input  logic                               out_ready,
  output logic                               err
);

  localparam int LOG2N = $clog2(N);
  localparam int SW    = $clog2(LOG2N + 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_CALC  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [LOG2N-1:0]   r_cnt;
  logic [SW-1:0]      r_stage;
  logic [W-1:0]       r_bank [N];
  logic               r_err;
  logic [LOG2N-1:0]   w_fill_addr;

  function automatic logic [LOG2N-1:0] f_rev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
    return r;
  endfunction

  always_comb begin
    w_fill_addr = (BITREV != 0) ? f_rev(r_cnt) : r_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_stage <= '0;
      r_bank  <= '{default: '0};
      r_err   <= 1'b0;
    end else begin
      if ((wb_valid || stage_done) && (r_state != S_CALC)) r_err <= 1'b1;
      // flush overrides every same-cycle write and beat; the bank keeps its contents
      if (flush) begin
        r_state <= S_FILL;
        r_cnt   <= '0;
        r_stage <= '0;
      end else begin
        case (r_state)
          S_FILL: begin
            if (in_valid) begin
              r_bank[w_fill_addr] <= in_data;
              if (r_cnt == LOG2N'(N-1)) begin
                r_cnt   <= '0;
                r_stage <= '0;
                r_state <= S_CALC;
              end else begin
                r_cnt <= r_cnt + LOG2N'(1);
              end
            end
          end
          S_CALC: begin
            if (wb_valid) r_bank[wb_addr] <= wb_data;
            if (stage_done) begin
              if (r_stage == SW'(LOG2N-1)) begin
                r_stage <= '0;
                r_cnt   <= '0;
                r_state <= S_DRAIN;
              end else begin
                r_stage <= r_stage + SW'(1);
              end
            end
          end
          S_DRAIN: begin
            if (out_ready) begin
              if (r_cnt == LOG2N'(N-1)) begin
                r_cnt   <= '0;
                r_state <= S_FILL;
              end else begin
                r_cnt <= r_cnt + LOG2N'(1);
              end
            end
          end
          default: begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_stage <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < N; i++) data_out[i*W +: W] = r_bank[i];
  end

  always_comb begin
    out_data = '0;
    if (r_state == S_DRAIN) out_data = r_bank[r_cnt];
  end

  assign in_ready    = (r_state == S_FILL);
  assign calc_active = (r_state == S_CALC);
  assign out_valid   = (r_state == S_DRAIN);
  assign out_last    = (r_state == S_DRAIN) && (r_cnt == LOG2N'(N-1));
  assign stage       = r_stage;
  assign err         = r_err;

endmodule
